// File: rtl/coproc_pkg.sv
// Shared types, frame geometry and opcode decode for the coprocessor SPI dispatcher.
package coproc_pkg;

    localparam int FRAME_W  = 72;
    localparam int RESULT_W = 32;
    localparam int BITCNT_W = 7;

    localparam logic [BITCNT_W-1:0] TX_BITS = 7'd72;
    localparam logic [BITCNT_W-1:0] RX_BITS = 7'd32;

    // Encoding doubles as the cs_n / miso bit index for the three real units.
    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_MUL = 2'd1,
        UNIT_SHF = 2'd2,
        UNIT_ILL = 2'd3
    } unit_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RECEIVE = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    function automatic unit_e decode_unit(input logic [3:0] opcode);
        unit_e unit;
        if (opcode <= 4'd5) begin
            unit = UNIT_ALU;
        end else if (opcode <= 4'd8) begin
            unit = UNIT_SHF;
        end else if (opcode == 4'd9) begin
            unit = UNIT_MUL;
        end else begin
            unit = UNIT_ILL;
        end
        return unit;
    endfunction

    function automatic logic [2:0] unit_cs_n(input unit_e unit);
        logic [2:0] cs;
        case (unit)
            UNIT_ALU: cs = 3'b110;
            UNIT_MUL: cs = 3'b101;
            UNIT_SHF: cs = 3'b011;
            default:  cs = 3'b111;
        endcase
        return cs;
    endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Mode-0 SPI bit engine: runs one phase (72-bit transmit or 32-bit receive) per load pulse.
module spi_master_shifter
    import coproc_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_load_tx,
    input  logic                i_load_rx,
    input  logic [FRAME_W-1:0]  i_frame,
    input  logic                i_miso,
    output logic                o_sclk,
    output logic                o_mosi,
    output logic                o_done,
    output logic [RESULT_W-1:0] o_rx_data
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic                r_active;
    logic                r_rx_mode;
    logic                r_sclk;
    logic                r_mosi;
    logic [DIV_W-1:0]    r_div;
    logic [BITCNT_W-1:0] r_bits;
    logic [FRAME_W-1:0]  r_tx;
    logic [RESULT_W-1:0] r_rx;

    logic w_tick;
    logic w_rise;
    logic w_fall;
    logic w_last;

    assign w_tick = r_active && (r_div == DIV_LAST);
    assign w_rise = w_tick && !r_sclk;
    assign w_fall = w_tick && r_sclk;
    // The falling edge that closes the final bit period ends the phase.
    assign w_last = w_fall && (r_bits == 7'd1);

    // Half-period divider, sclk toggling, transmit shifting and receive sampling.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_active  <= 1'b0;
            r_rx_mode <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_div     <= '0;
            r_bits    <= 7'd0;
            r_tx      <= '0;
            r_rx      <= '0;
        end else if (i_load_tx) begin
            r_active  <= 1'b1;
            r_rx_mode <= 1'b0;
            r_sclk    <= 1'b0;
            r_div     <= '0;
            r_bits    <= TX_BITS;
            r_tx      <= i_frame;
            r_mosi    <= i_frame[FRAME_W-1];
        end else if (i_load_rx) begin
            r_active  <= 1'b1;
            r_rx_mode <= 1'b1;
            r_sclk    <= 1'b0;
            r_div     <= '0;
            r_bits    <= RX_BITS;
            r_mosi    <= 1'b0;
            r_rx      <= '0;
        end else if (r_active) begin
            if (w_tick) begin
                r_div  <= '0;
                r_sclk <= !r_sclk;
                if (w_rise && r_rx_mode) begin
                    r_rx <= {r_rx[RESULT_W-2:0], i_miso};
                end
                if (w_fall) begin
                    r_bits <= r_bits - 7'd1;
                    if (w_last) begin
                        r_active <= 1'b0;
                        r_mosi   <= 1'b0;
                    end else if (!r_rx_mode) begin
                        r_mosi <= r_tx[FRAME_W-2];
                        r_tx   <= {r_tx[FRAME_W-2:0], 1'b0};
                    end
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign o_sclk    = r_sclk;
    assign o_mosi    = r_mosi;
    assign o_done    = w_last;
    assign o_rx_data = r_rx;

endmodule

// File: rtl/coproc_spi_dispatcher.sv
// Dispatches one opcode/operand request at a time over a shared SPI bus to the ALU,
// multiplier or barrel shifter and returns the 32-bit result with the request tag.
module coproc_spi_dispatcher
    import coproc_pkg::*;
#(
    parameter int CLK_DIV    = 1,
    parameter int TURNAROUND = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_opcode,
    input  logic [3:0]  req_rd,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_rd,
    output logic        rsp_error,
    output logic        busy,
    output logic        sclk,
    output logic        mosi,
    output logic [2:0]  cs_n,
    input  logic [2:0]  miso
);

    localparam int WAIT_CYC = TURNAROUND * 2 * CLK_DIV;

    state_e      r_state;
    unit_e       r_unit;
    logic [3:0]  r_rd;
    logic [15:0] r_wait;
    logic [2:0]  r_cs_n;
    logic        r_req_ready;
    logic        r_busy;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_result;
    logic [3:0]  r_rsp_rd;
    logic        r_rsp_error;

    state_e      w_state_nxt;
    unit_e       w_dec_unit;
    unit_e       w_unit_sel;
    logic        w_load_tx;
    logic        w_load_rx;
    logic        w_miso;
    logic        w_done;
    logic        w_in_xfer;
    logic [31:0] w_rx_data;

    assign w_dec_unit = decode_unit(req_opcode);
    assign w_unit_sel = (r_state == ST_IDLE) ? w_dec_unit : r_unit;
    assign w_in_xfer  = (w_state_nxt == ST_SEND) || (w_state_nxt == ST_WAIT) ||
                        (w_state_nxt == ST_RECEIVE);

    // Route the addressed unit's data line into the shared receive path.
    always_comb begin
        case (r_unit)
            UNIT_ALU: w_miso = miso[0];
            UNIT_MUL: w_miso = miso[1];
            UNIT_SHF: w_miso = miso[2];
            default:  w_miso = 1'b0;
        endcase
    end

    // Next-state decode and phase-start pulses for the shifter.
    always_comb begin
        w_state_nxt = r_state;
        w_load_tx   = 1'b0;
        w_load_rx   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_dec_unit == UNIT_ILL) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_SEND;
                        w_load_tx   = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (w_done && (WAIT_CYC == 0)) begin
                    w_state_nxt = ST_RECEIVE;
                    w_load_rx   = 1'b1;
                end else if (w_done) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_WAIT: begin
                if (r_wait == 16'd0) begin
                    w_state_nxt = ST_RECEIVE;
                    w_load_rx   = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_RECEIVE: begin
                if (w_done) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_RECEIVE;
                end
            end
            ST_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register plus registered handshake, select and response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_unit       <= UNIT_ALU;
            r_rd         <= 4'd0;
            r_wait       <= 16'd0;
            r_cs_n       <= 3'b111;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 32'd0;
            r_rsp_rd     <= 4'd0;
            r_rsp_error  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_cs_n      <= w_in_xfer ? unit_cs_n(w_unit_sel) : 3'b111;
            // Valid trails RESP entry by a cycle and drops on the handshake edge.
            r_rsp_valid <= (r_state == ST_RESP) && (w_state_nxt == ST_RESP);

            if ((r_state == ST_IDLE) && req_valid) begin
                r_unit <= w_dec_unit;
                r_rd   <= req_rd;
                if (w_dec_unit == UNIT_ILL) begin
                    r_rsp_result <= 32'd0;
                    r_rsp_rd     <= req_rd;
                    r_rsp_error  <= 1'b1;
                end
            end

            if ((r_state == ST_RECEIVE) && w_done) begin
                r_rsp_result <= w_rx_data;
                r_rsp_rd     <= r_rd;
                r_rsp_error  <= 1'b0;
            end

            if ((r_state == ST_SEND) && w_done) begin
                r_wait <= 16'(WAIT_CYC - 1);
            end else if ((r_state == ST_WAIT) && (r_wait != 16'd0)) begin
                r_wait <= r_wait - 16'd1;
            end
        end
    end

    spi_master_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clock     (clock),
        .reset     (reset),
        .i_load_tx (w_load_tx),
        .i_load_rx (w_load_rx),
        .i_frame   ({req_opcode, 4'b0000, req_a, req_b}),
        .i_miso    (w_miso),
        .o_sclk    (sclk),
        .o_mosi    (mosi),
        .o_done    (w_done),
        .o_rx_data (w_rx_data)
    );

    assign req_ready  = r_req_ready;
    assign busy       = r_busy;
    assign cs_n       = r_cs_n;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_rd     = r_rsp_rd;
    assign rsp_error  = r_rsp_error;

endmodule

// File: tb/tb_coproc_spi_dispatcher.sv
// Self-checking bench: behavioural SPI slave units plus a transaction-level reference model.
module tb_coproc_spi_dispatcher;

    localparam int CLK_DIV    = 1;
    localparam int TURNAROUND = 4;
    localparam int SEND_CYC   = 2 * CLK_DIV * 72;
    localparam int WAIT_CYC   = 2 * CLK_DIV * TURNAROUND;
    localparam int LEGAL_LAT  = 2 * CLK_DIV * (104 + TURNAROUND) + 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_opcode;
    logic [3:0]  req_rd;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_rd;
    logic        rsp_error;
    logic        busy;
    logic        sclk;
    logic        mosi;
    logic [2:0]  cs_n;
    logic [2:0]  miso;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    coproc_spi_dispatcher #(
        .CLK_DIV    (CLK_DIV),
        .TURNAROUND (TURNAROUND)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_rd     (req_rd),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_rd     (rsp_rd),
        .rsp_error  (rsp_error),
        .busy       (busy),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .miso       (miso)
    );

    // What each execution unit computes for an opcode.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return {31'd0, a < b};
            4'd6:    return a << b[4:0];
            4'd7:    return a >> b[4:0];
            4'd8:    return $signed(a) >>> b[4:0];
            4'd9:    return a * b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] ref_cs(input logic [3:0] op);
        if (op <= 4'd5)      return 3'b110;
        else if (op <= 4'd8) return 3'b011;
        else if (op == 4'd9) return 3'b101;
        else                 return 3'b111;
    endfunction

    // Behavioural slave: collects the 72-bit frame, then returns the result MSB first.
    logic        w_cs_idle;
    int          sl_cnt = 0;
    logic [71:0] sl_rx = '0;
    logic [71:0] sl_frame = '0;
    logic        sl_bit = 1'b0;
    logic [31:0] w_sl_res;

    assign w_cs_idle = &cs_n;
    assign w_sl_res  = ref_result(sl_frame[71:68], sl_frame[63:32], sl_frame[31:0]);
    assign miso[0]   = cs_n[0] ? ~sl_bit : sl_bit;
    assign miso[1]   = cs_n[1] ? ~sl_bit : sl_bit;
    assign miso[2]   = cs_n[2] ? ~sl_bit : sl_bit;

    always @(posedge sclk or posedge w_cs_idle) begin
        if (w_cs_idle) begin
            sl_cnt <= 0;
        end else begin
            if (sl_cnt < 72) sl_rx <= {sl_rx[70:0], mosi};
            if (sl_cnt == 71) sl_frame <= {sl_rx[70:0], mosi};
            sl_cnt <= sl_cnt + 1;
        end
    end

    always @(negedge sclk or posedge w_cs_idle) begin
        if (w_cs_idle) begin
            sl_bit <= 1'b0;
        end else if (sl_cnt >= 72 && sl_cnt < 104) begin
            sl_bit <= w_sl_res[103 - sl_cnt];
        end
    end

    task automatic check_eq(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge following the accept edge.
    task automatic start_req(input logic [3:0] op, input logic [3:0] rd,
                             input logic [31:0] a, input logic [31:0] b, input bit keep_valid);
        int n = 0;
        while (req_ready !== 1'b1 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check_eq("accept_ready", req_ready, 1'b1);
        req_opcode = op;
        req_rd     = rd;
        req_a      = a;
        req_b      = b;
        req_valid  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (!keep_valid) req_valid = 1'b0;
    endtask

    task automatic run_txn(input logic [3:0] op, input logic [3:0] rd, input logic [31:0] a,
                           input logic [31:0] b, input int hold, input bit keep_valid);
        bit          legal;
        int          lat, first, rises, cs_bad, quiet_bad, rdy_bad, hold_bad;
        logic        prev;
        logic [2:0]  exp_cs;
        logic [31:0] exp_res;

        legal   = (op <= 4'd9);
        lat     = legal ? LEGAL_LAT : 1;
        exp_res = legal ? ref_result(op, a, b) : 32'd0;
        first = -1; rises = 0; cs_bad = 0; quiet_bad = 0; rdy_bad = 0; hold_bad = 0;
        prev  = 1'b0;
        rsp_ready = 1'b0;
        start_req(op, rd, a, b, keep_valid);
        for (int i = 0; i <= lat + 4; i++) begin
            if (i > 0) @(negedge clock);
            if (rsp_valid === 1'b1) begin
                first = i;
                break;
            end
            exp_cs = (legal && i < lat - 1) ? ref_cs(op) : 3'b111;
            if (cs_n !== exp_cs) cs_bad++;
            if (sclk === 1'b1 && prev === 1'b0) rises++;
            prev = sclk;
            if (i >= SEND_CYC && i < SEND_CYC + WAIT_CYC && (sclk !== 1'b0 || mosi !== 1'b0))
                quiet_bad++;
            if (req_ready !== 1'b0 || busy !== 1'b1) rdy_bad++;
            if (keep_valid) begin
                req_opcode = 4'($urandom);
                req_a      = $urandom;
                req_b      = $urandom;
            end
        end
        check_eq("latency", first, lat);
        check_eq("cs_n_window", cs_bad, 0);
        check_eq("sclk_rises", rises, legal ? 104 : 0);
        check_eq("wait_quiet", quiet_bad, 0);
        check_eq("busy_not_ready", rdy_bad, 0);
        check_eq("rsp_result", rsp_result, exp_res);
        check_eq("rsp_rd", rsp_rd, rd);
        check_eq("rsp_error", rsp_error, !legal);
        if (legal) check_eq("frame", sl_frame, {op, 4'b0000, a, b});
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b1 || rsp_result !== exp_res || rsp_rd !== rd ||
                rsp_error !== !legal || req_ready !== 1'b0)
                hold_bad++;
        end
        check_eq("rsp_hold", hold_bad, 0);
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        check_eq("back_to_idle", {rsp_valid, req_ready, busy, cs_n}, {3'b010, 3'b111});
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_opcode = 4'd0; req_rd = 4'd0; req_a = 32'd0; req_b = 32'd0;
        repeat (3) @(negedge clock);
        check_eq("reset_state",
                 {cs_n, sclk, mosi, rsp_valid, rsp_result, rsp_rd, rsp_error, busy, req_ready},
                 {3'b111, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1});
        reset = 1'b0;
        @(negedge clock);

        run_txn(4'b0001, 4'd3, 32'd5, 32'd3, 0, 1'b0);
        run_txn(4'b1001, 4'd9, 32'd7, 32'd6, 2, 1'b0);
        run_txn(4'b1111, 4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 1, 1'b0);

        start_req(4'b0010, 4'd5, 32'hAAAA_5555, 32'h0F0F_F0F0, 1'b0);
        repeat (2 * CLK_DIV * 20) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_eq("mid_reset", {cs_n, sclk, mosi, req_ready, busy, rsp_valid},
                 {3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        run_txn(4'b0111, 4'd6, 32'h8000_0F00, 32'd4, 0, 1'b0);

        run_txn(4'b0100, 4'd1, 32'h1357_9BDF, 32'h2468_ACE0, 10, 1'b1);
        run_txn(4'b1000, 4'd14, 32'h8000_0000, 32'd31, 0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            run_txn(4'($urandom_range(0, 15)), 4'($urandom), $urandom, $urandom,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
